reg_file: RTL

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 72 +++++++
 1 files changed

// File: rtl/reg_file.sv
// Two-read, one-write register file with byte enables, optional
// hardwired-zero register 0 and optional same-cycle write forwarding.
module reg_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [WIDTH/8-1:0]   wbe,
    input  logic [ADDR_W-1:0]    raddr_a,
    output logic [WIDTH-1:0]     rdata_a,
    input  logic [ADDR_W-1:0]    raddr_b,
    output logic [WIDTH-1:0]     rdata_b
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] bmask;
    logic [WIDTH-1:0] wmerge_d;
    logic             wzero;
    logic             wr_en;

    always_comb begin
        bmask = '0;
        for (int b = 0; b < NB; b++) begin
            bmask[8*b +: 8] = {8{wbe[b]}};
        end
    end

    // Writes to a hardwired-zero register 0 are dropped entirely.
    assign wzero = (ZERO_REG != 0) && (waddr == '0);
    assign wr_en = we && (|wbe) && !wzero;
    assign wmerge_d = (regs_q[waddr] & ~bmask) | (wdata & bmask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr] <= wmerge_d;
        end
    end

    always_comb begin
        rdata_a = regs_q[raddr_a];
        if ((BYPASS != 0) && wr_en && (raddr_a == waddr)) begin
            rdata_a = (rdata_a & ~bmask) | (wdata & bmask);
        end
        if (!reset || ((ZERO_REG != 0) && (raddr_a == '0))) begin
            rdata_a = '0;
        end
    end

    always_comb begin
        rdata_b = regs_q[raddr_b];
        if ((BYPASS != 0) && wr_en && (raddr_b == waddr)) begin
            rdata_b = (rdata_b & ~bmask) | (wdata & bmask);
        end
        if (!reset || ((ZERO_REG != 0) && (raddr_b == '0))) begin
            rdata_b = '0;
        end
    end

endmodule
